// File: rtl/debug_unit.sv
// UART debug unit: loads program words, runs or single-steps the core, then dumps PC/registers/memory.
// Optional macro DEBUG_CYCLE_COUNT_EN adds a saturating enabled-cycle counter to the dump after the PC.
`ifndef ADDRWIDTH
`define ADDRWIDTH 32
`endif

module debug_unit #(
  parameter int NB_DATA     = 32,
  parameter int NB_REG      = 5,
  parameter int N_REGISTER  = 32,
  parameter int N_MEM_WORDS = 16,
  parameter int N_BITS      = 8
) (
  input  logic                  clock,
  input  logic                  i_reset,
  input  logic [N_BITS-1:0]     i_rx_data,
  input  logic                  i_rx_done,
  input  logic                  i_tx_done,
  output logic [N_BITS-1:0]     o_tx_data,
  output logic                  o_tx_start,
  output logic [NB_DATA-1:0]    o_im_data,
  output logic [`ADDRWIDTH-1:0] o_im_addr,
  output logic                  o_im_enable_write,
  output logic                  o_en_read,
  output logic                  o_debug_unit,
  output logic                  o_enable_pipe,
  output logic                  o_enable_mem,
  output logic                  o_dm_enable_read,
  output logic [NB_REG-1:0]     o_br_addr,
  output logic                  o_br_enable,
  output logic [`ADDRWIDTH-1:0] o_dm_addr,
  output logic                  o_dm_enable,
  output logic                  o_dm_enable_addr,
  input  logic [`ADDRWIDTH-1:0] i_send_pc,
  input  logic [NB_DATA-1:0]    i_data_reg,
  input  logic [NB_DATA-1:0]    i_data_mem,
  input  logic                  i_halt
);
  localparam int AW = `ADDRWIDTH;
`ifdef DEBUG_CYCLE_COUNT_EN
  localparam int HDR = 2;
`else
  localparam int HDR = 1;
`endif
  localparam int DUMP_WORDS = HDR + N_REGISTER + N_MEM_WORDS;
  localparam int DW  = $clog2(DUMP_WORDS + 1);
  localparam int BPW = NB_DATA / N_BITS;
  localparam int BW  = $clog2(BPW);
  localparam logic [DW-1:0] REG_BASE  = DW'(HDR);
  localparam logic [DW-1:0] MEM_BASE  = DW'(HDR + N_REGISTER);
  localparam logic [DW-1:0] LAST_WORD = DW'(DUMP_WORDS - 1);
  localparam logic [BW-1:0] LAST_BYTE = BW'(BPW - 1);
  localparam logic [N_BITS-1:0] CMD_LOAD = N_BITS'('h4C);
  localparam logic [N_BITS-1:0] CMD_RUN  = N_BITS'('h43);
  localparam logic [N_BITS-1:0] CMD_STEP = N_BITS'('h53);

  typedef enum logic [3:0] {
    IDLE, LOAD_CNT, LOAD_BYTE, LOAD_WRITE, RUN, STEP, DUMP_FETCH, DUMP_SEND, DUMP_WAIT
  } state_t;

  state_t             state_q, state_d;
  logic [N_BITS-1:0]  cnt_q, cnt_d;
  logic [N_BITS-1:0]  widx_q, widx_d;
  logic [BW-1:0]      bidx_q, bidx_d;
  logic [NB_DATA-1:0] im_data_q, im_data_d;
  logic [DW-1:0]      didx_q, didx_d;
  logic               fetch_wait_q, fetch_wait_d;
  logic [NB_DATA-1:0] tx_word_q, tx_word_d;
  logic [NB_DATA-1:0] pc_ext, hdr_word;
  logic [DW-1:0]      mem_idx;
  logic               pipe_en, reg_phase, mem_phase;
  logic [N_BITS-1:0]  tx_bytes [BPW];

  assign pc_ext  = NB_DATA'(i_send_pc);
  assign mem_idx = didx_q - MEM_BASE;

`ifdef DEBUG_CYCLE_COUNT_EN
  logic [31:0] cycles_q, cycles_d;

  // Cleared by an 'L' command; sticks at all-ones instead of wrapping.
  always_comb begin
    cycles_d = cycles_q;
    if (state_q == IDLE && i_rx_done && i_rx_data == CMD_LOAD) cycles_d = '0;
    else if (pipe_en && cycles_q != '1) cycles_d = cycles_q + 32'd1;
  end

  always_ff @(posedge clock) begin
    if (i_reset) cycles_q <= '0;
    else         cycles_q <= cycles_d;
  end

  assign hdr_word = (didx_q == '0) ? pc_ext : NB_DATA'(cycles_q);
`else
  assign hdr_word = pc_ext;
`endif

  // Byte lanes of the word being transmitted, lane 0 = MSB.
  for (genvar gi = 0; gi < BPW; gi++) begin : g_tx_lane
    assign tx_bytes[gi] = tx_word_q[NB_DATA-1-gi*N_BITS -: N_BITS];
  end

  always_ff @(posedge clock) begin
    if (i_reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      widx_q       <= '0;
      bidx_q       <= '0;
      im_data_q    <= '0;
      didx_q       <= '0;
      fetch_wait_q <= 1'b0;
      tx_word_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      widx_q       <= widx_d;
      bidx_q       <= bidx_d;
      im_data_q    <= im_data_d;
      didx_q       <= didx_d;
      fetch_wait_q <= fetch_wait_d;
      tx_word_q    <= tx_word_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    widx_d       = widx_q;
    bidx_d       = bidx_q;
    im_data_d    = im_data_q;
    didx_d       = didx_q;
    fetch_wait_d = fetch_wait_q;
    tx_word_d    = tx_word_q;
    case (state_q)
      IDLE: begin
        widx_d       = '0;
        bidx_d       = '0;
        didx_d       = '0;
        fetch_wait_d = 1'b0;
        if (i_rx_done) begin
          if (i_rx_data == CMD_LOAD)      state_d = LOAD_CNT;
          else if (i_rx_data == CMD_RUN)  state_d = RUN;
          else if (i_rx_data == CMD_STEP) state_d = STEP;
        end
      end
      LOAD_CNT: if (i_rx_done) begin
        cnt_d   = i_rx_data;
        state_d = (i_rx_data == '0) ? IDLE : LOAD_BYTE;
      end
      LOAD_BYTE: if (i_rx_done) begin
        im_data_d = {im_data_q[NB_DATA-N_BITS-1:0], i_rx_data};
        bidx_d    = bidx_q + BW'(1);
        if (bidx_q == LAST_BYTE) state_d = LOAD_WRITE;
      end
      LOAD_WRITE: begin
        if (widx_q + N_BITS'(1) == cnt_q) begin
          state_d = IDLE;
        end else begin
          widx_d  = widx_q + N_BITS'(1);
          state_d = LOAD_BYTE;
        end
      end
      RUN:  if (i_halt) state_d = DUMP_FETCH;
      STEP: state_d = DUMP_FETCH;
      DUMP_FETCH: begin
        // Header words are local; register/memory words need one cycle of read latency.
        if (didx_q < REG_BASE) begin
          tx_word_d = hdr_word;
          state_d   = DUMP_SEND;
        end else if (!fetch_wait_q) begin
          fetch_wait_d = 1'b1;
        end else begin
          fetch_wait_d = 1'b0;
          tx_word_d    = (didx_q < MEM_BASE) ? i_data_reg : i_data_mem;
          state_d      = DUMP_SEND;
        end
      end
      DUMP_SEND: state_d = DUMP_WAIT;
      DUMP_WAIT: if (i_tx_done) begin
        bidx_d = bidx_q + BW'(1);
        if (bidx_q != LAST_BYTE) begin
          state_d = DUMP_SEND;
        end else if (didx_q == LAST_WORD) begin
          state_d = IDLE;
        end else begin
          didx_d  = didx_q + DW'(1);
          state_d = DUMP_FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pipe_en   = (state_q == RUN || state_q == STEP) && !i_halt;
    reg_phase = (state_q == DUMP_FETCH) && didx_q >= REG_BASE && didx_q < MEM_BASE;
    mem_phase = (state_q == DUMP_FETCH) && didx_q >= MEM_BASE;

    o_debug_unit      = (state_q == LOAD_CNT || state_q == LOAD_BYTE || state_q == LOAD_WRITE);
    o_en_read         = !o_debug_unit;
    o_im_data         = im_data_q;
    o_im_addr         = AW'({widx_q, 2'b00});
    o_im_enable_write = (state_q == LOAD_WRITE);
    o_enable_pipe     = pipe_en;
    o_enable_mem      = pipe_en || mem_phase;
    o_dm_enable_read  = mem_phase;
    o_br_enable       = reg_phase;
    o_br_addr         = reg_phase ? NB_REG'(didx_q - REG_BASE) : '0;
    o_dm_enable       = mem_phase;
    o_dm_enable_addr  = mem_phase;
    o_dm_addr         = mem_phase ? AW'({mem_idx, 2'b00}) : '0;
    o_tx_start        = (state_q == DUMP_SEND);
    o_tx_data         = (state_q == DUMP_SEND || state_q == DUMP_WAIT) ? tx_bytes[bidx_q] : '0;
  end

endmodule

// File: tb/tb_debug_unit.sv
// Testbench for debug_unit: UART command stimulus, register/memory models and a dump scoreboard.
`ifndef ADDRWIDTH
`define ADDRWIDTH 32
`endif

module tb_debug_unit;
  localparam int AW = `ADDRWIDTH;
`ifdef DEBUG_CYCLE_COUNT_EN
  localparam int DUMP_LEN = 200;
`else
  localparam int DUMP_LEN = 196;
`endif

  logic          clock = 1'b0;
  logic          i_reset = 1'b1;
  logic [7:0]    i_rx_data = '0;
  logic          i_rx_done = 1'b0;
  logic          i_tx_done = 1'b0;
  logic [AW-1:0] i_send_pc = '0;
  logic [31:0]   i_data_reg = '0;
  logic [31:0]   i_data_mem = '0;
  logic          i_halt = 1'b0;
  logic [7:0]    o_tx_data;
  logic          o_tx_start;
  logic [31:0]   o_im_data;
  logic [AW-1:0] o_im_addr;
  logic          o_im_enable_write, o_en_read, o_debug_unit, o_enable_pipe;
  logic          o_enable_mem, o_dm_enable_read, o_br_enable, o_dm_enable, o_dm_enable_addr;
  logic [4:0]    o_br_addr;
  logic [AW-1:0] o_dm_addr;

  debug_unit dut (
    .clock(clock), .i_reset(i_reset),
    .i_rx_data(i_rx_data), .i_rx_done(i_rx_done), .i_tx_done(i_tx_done),
    .o_tx_data(o_tx_data), .o_tx_start(o_tx_start),
    .o_im_data(o_im_data), .o_im_addr(o_im_addr), .o_im_enable_write(o_im_enable_write),
    .o_en_read(o_en_read), .o_debug_unit(o_debug_unit),
    .o_enable_pipe(o_enable_pipe), .o_enable_mem(o_enable_mem), .o_dm_enable_read(o_dm_enable_read),
    .o_br_addr(o_br_addr), .o_br_enable(o_br_enable),
    .o_dm_addr(o_dm_addr), .o_dm_enable(o_dm_enable), .o_dm_enable_addr(o_dm_enable_addr),
    .i_send_pc(i_send_pc), .i_data_reg(i_data_reg), .i_data_mem(i_data_mem), .i_halt(i_halt)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int model_cycles = 0;
  int stall_bad;
  logic [31:0] regs [32];
  logic [31:0] mem  [16];
  logic [7:0]  dump_q [$];
  logic [7:0]  exp_q  [$];
  logic [AW-1:0] wr_addr_q [$];
  logic [31:0]   wr_data_q [$];
  int pipe_cnt = 0;
  int tx_cnt = 0;

  // Register file and data memory with one-cycle registered read.
  always @(posedge clock) begin
    if (o_br_enable) i_data_reg <= regs[o_br_addr];
    if (o_dm_enable) i_data_mem <= mem[o_dm_addr[5:2]];
  end

  always @(negedge clock) begin
    if (o_enable_pipe === 1'b1) pipe_cnt++;
    if (o_tx_start === 1'b1) tx_cnt++;
    if (o_im_enable_write === 1'b1) begin
      wr_addr_q.push_back(o_im_addr);
      wr_data_q.push_back(o_im_data);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    tick();
    i_rx_data = b;
    i_rx_done = 1'b1;
    tick();
    i_rx_done = 1'b0;
  endtask

  // Every output except o_en_read, packed; all must be zero at reset.
  function automatic logic [127:0] other_outs();
    return 128'({o_tx_data, o_tx_start, o_im_data, o_im_addr, o_im_enable_write, o_debug_unit,
                 o_enable_pipe, o_enable_mem, o_dm_enable_read, o_br_addr, o_br_enable,
                 o_dm_addr, o_dm_enable, o_dm_enable_addr});
  endfunction

  task automatic randomize_model();
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
  endtask

  task automatic push_word(input logic [31:0] w);
    exp_q.push_back(w[31:24]);
    exp_q.push_back(w[23:16]);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
  endtask

  task automatic build_expected();
    exp_q.delete();
    push_word(32'(i_send_pc));
`ifdef DEBUG_CYCLE_COUNT_EN
    push_word(32'(model_cycles));
`endif
    for (int r = 0; r < 32; r++) push_word(regs[r]);
    for (int m = 0; m < 16; m++) push_word(mem[m]);
  endtask

  // UART transmitter stand-in: capture each byte, hold off i_tx_done for 'delay' cycles.
  task automatic collect_dump(input int delay, input int max_bytes);
    bit got;
    logic [7:0] b;
    dump_q.delete();
    stall_bad = 0;
    while (dump_q.size() < max_bytes) begin
      got = 0;
      for (int w = 0; w < 300 && !got; w++) begin
        @(negedge clock);
        if (o_tx_start === 1'b1) got = 1;
      end
      if (!got) break;
      b = o_tx_data;
      dump_q.push_back(b);
      for (int d = 0; d < delay; d++) begin
        @(negedge clock);
        if (o_tx_data !== b || o_tx_start !== 1'b0) stall_bad++;
      end
      @(posedge clock); #1; i_tx_done = 1'b1;
      @(negedge clock);
      if (o_tx_start !== 1'b0) stall_bad++;
      @(posedge clock); #1; i_tx_done = 1'b0;
    end
  endtask

  task automatic check_dump(input string name);
    int bad_idx;
    build_expected();
    checks++;
    if (dump_q.size() !== DUMP_LEN) begin
      errors++;
      $display("FAIL %s_len: got %0d bytes, expected %0d", name, dump_q.size(), DUMP_LEN);
    end
    bad_idx = -1;
    for (int i = 0; i < dump_q.size() && i < exp_q.size(); i++)
      if (bad_idx < 0 && dump_q[i] !== exp_q[i]) bad_idx = i;
    checks++;
    if (bad_idx >= 0) begin
      errors++;
      $display("FAIL %s_data: byte %0d got %02h, expected %02h", name, bad_idx, dump_q[bad_idx], exp_q[bad_idx]);
    end
    $display("%s: dump of %0d bytes captured", name, dump_q.size());
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    repeat (3) tick();
    checks++;
    if (o_en_read !== 1'b1 || other_outs() !== '0) begin
      errors++;
      $display("FAIL reset_outputs: en_read=%b others=%h, expected en_read=1 others=0", o_en_read, other_outs());
    end
    i_reset = 1'b0;
    tick();
    checks++;
    if (o_en_read !== 1'b1 || other_outs() !== '0) begin
      errors++;
      $display("FAIL idle_outputs: en_read=%b others=%h, expected en_read=1 others=0", o_en_read, other_outs());
    end
    model_cycles = 0;
    $display("test_reset: done");
  endtask

  task automatic test_load();
    int base;
    logic [7:0] bytes [8];
    bytes = '{8'h20, 8'h01, 8'h00, 8'h05, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    base = wr_addr_q.size();
    send_byte(8'h4C);
    checks++;
    if (o_debug_unit !== 1'b1 || o_en_read !== 1'b0) begin
      errors++;
      $display("FAIL load_mode: debug_unit=%b en_read=%b, expected 1/0", o_debug_unit, o_en_read);
    end
    send_byte(8'h02);
    for (int i = 0; i < 8; i++) send_byte(bytes[i]);
    tick();
    checks++;
    if (o_debug_unit !== 1'b0 || o_en_read !== 1'b1) begin
      errors++;
      $display("FAIL load_exit: debug_unit=%b en_read=%b, expected 0/1", o_debug_unit, o_en_read);
    end
    checks++;
    if (wr_addr_q.size() - base !== 2) begin
      errors++;
      $display("FAIL load_count: got %0d writes, expected 2", wr_addr_q.size() - base);
    end else begin
      checks++;
      if (wr_addr_q[base] !== AW'(0) || wr_data_q[base] !== 32'h20010005) begin
        errors++;
        $display("FAIL load_word0: addr=%0h data=%h, expected addr=0 data=20010005", wr_addr_q[base], wr_data_q[base]);
      end
      checks++;
      if (wr_addr_q[base+1] !== AW'(4) || wr_data_q[base+1] !== 32'hFFFFFFFF) begin
        errors++;
        $display("FAIL load_word1: addr=%0h data=%h, expected addr=4 data=ffffffff", wr_addr_q[base+1], wr_data_q[base+1]);
      end
    end
    model_cycles = 0;
    $display("test_load: %0d writes observed", wr_addr_q.size() - base);
  endtask

  task automatic test_load_zero();
    int base;
    base = wr_addr_q.size();
    send_byte(8'h4C);
    send_byte(8'h00);
    repeat (5) tick();
    checks++;
    if (wr_addr_q.size() !== base || o_debug_unit !== 1'b0) begin
      errors++;
      $display("FAIL load_zero: writes=%0d debug_unit=%b, expected 0 writes and 0", wr_addr_q.size() - base, o_debug_unit);
    end
    model_cycles = 0;
    $display("test_load_zero: done");
  endtask

  task automatic test_random_load();
    int n, base;
    logic [31:0] words [8];
    for (int t = 0; t < 4; t++) begin
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) words[k] = $urandom;
      base = wr_addr_q.size();
      send_byte(8'h4C);
      send_byte(8'(n));
      for (int k = 0; k < n; k++) begin
        send_byte(words[k][31:24]);
        send_byte(words[k][23:16]);
        send_byte(words[k][15:8]);
        send_byte(words[k][7:0]);
      end
      repeat (2) tick();
      checks++;
      if (wr_addr_q.size() - base !== n) begin
        errors++;
        $display("FAIL rand_load_count: got %0d writes, expected %0d", wr_addr_q.size() - base, n);
      end else begin
        for (int k = 0; k < n; k++) begin
          checks++;
          if (wr_addr_q[base+k] !== AW'(4*k) || wr_data_q[base+k] !== words[k]) begin
            errors++;
            $display("FAIL rand_load_word%0d: addr=%0h data=%h, expected addr=%0h data=%h",
                     k, wr_addr_q[base+k], wr_data_q[base+k], 4*k, words[k]);
          end
        end
      end
      $display("test_random_load: trial %0d wrote %0d words", t, n);
    end
    model_cycles = 0;
  endtask

  task automatic test_ignore();
    int bad, tx0, wr0;
    tx0 = tx_cnt;
    wr0 = wr_addr_q.size();
    bad = 0;
    send_byte(8'h7A);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (o_debug_unit !== 1'b0 || o_enable_pipe !== 1'b0 || o_en_read !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0 || tx_cnt != tx0 || wr_addr_q.size() != wr0) begin
      errors++;
      $display("FAIL ignore_cmd: bad_cycles=%0d tx=%0d writes=%0d, expected all 0", bad, tx_cnt - tx0, wr_addr_q.size() - wr0);
    end
    $display("test_ignore: done");
  endtask

  task automatic test_run();
    int base;
    randomize_model();
    i_send_pc = AW'($urandom_range(0, 1023) * 4);
    i_halt = 1'b0;
    base = pipe_cnt;
    send_byte(8'h43);
    repeat (10) tick();
    i_halt = 1'b1;
    collect_dump(0, 1000);
    checks++;
    if (pipe_cnt - base !== 10) begin
      errors++;
      $display("FAIL run_pipe_cycles: got %0d, expected 10", pipe_cnt - base);
    end
    model_cycles += 10;
    check_dump("run_dump");
  endtask

  task automatic test_step();
    int base;
    randomize_model();
    i_send_pc = AW'(8);
    i_halt = 1'b0;
    base = pipe_cnt;
    send_byte(8'h53);
    collect_dump(0, 1000);
    checks++;
    if (pipe_cnt - base !== 1) begin
      errors++;
      $display("FAIL step_pulse: got %0d pipe cycles, expected 1", pipe_cnt - base);
    end
    checks++;
    if (dump_q.size() < 4 || dump_q[0] !== 8'h00 || dump_q[1] !== 8'h00 || dump_q[2] !== 8'h00 || dump_q[3] !== 8'h08) begin
      errors++;
      $display("FAIL step_pc_bytes: got %0d bytes starting %p, expected 00 00 00 08", dump_q.size(), dump_q[0:3]);
    end
    model_cycles += 1;
    check_dump("step_dump");
  endtask

  task automatic test_step_halted();
    int base;
    randomize_model();
    i_send_pc = AW'($urandom_range(0, 1023) * 4);
    i_halt = 1'b1;
    base = pipe_cnt;
    send_byte(8'h53);
    send_byte(8'h4C);
    checks++;
    if (o_debug_unit !== 1'b0) begin
      errors++;
      $display("FAIL rx_in_dump: debug_unit=%b, expected 0", o_debug_unit);
    end
    collect_dump(0, 1000);
    checks++;
    if (pipe_cnt - base !== 0) begin
      errors++;
      $display("FAIL step_halted_pulse: got %0d pipe cycles, expected 0", pipe_cnt - base);
    end
    check_dump("step_halted_dump");
  endtask

  task automatic test_tx_stall();
    randomize_model();
    i_send_pc = AW'($urandom_range(0, 1023) * 4);
    i_halt = 1'b1;
    send_byte(8'h53);
    collect_dump(50, 1000);
    checks++;
    if (stall_bad !== 0) begin
      errors++;
      $display("FAIL tx_stall: got %0d unstable/extra-start cycles, expected 0", stall_bad);
    end
    check_dump("stall_dump");
  endtask

  task automatic test_abort();
    int wr0, tx0;
    wr0 = wr_addr_q.size();
    send_byte(8'h4C);
    send_byte(8'h01);
    send_byte(8'hAA);
    send_byte(8'hBB);
    tick();
    i_rx_data = 8'hCC;
    i_rx_done = 1'b1;
    i_reset = 1'b1;
    tick();
    i_rx_done = 1'b0;
    i_reset = 1'b0;
    checks++;
    if (o_en_read !== 1'b1 || other_outs() !== '0) begin
      errors++;
      $display("FAIL abort_load_outputs: en_read=%b others=%h, expected en_read=1 others=0", o_en_read, other_outs());
    end
    send_byte(8'hDD);
    repeat (10) tick();
    checks++;
    if (wr_addr_q.size() !== wr0) begin
      errors++;
      $display("FAIL abort_load_write: got %0d writes, expected 0", wr_addr_q.size() - wr0);
    end
    randomize_model();
    i_halt = 1'b1;
    send_byte(8'h53);
    collect_dump(0, 6);
    tick();
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    tx0 = tx_cnt;
    checks++;
    if (o_en_read !== 1'b1 || other_outs() !== '0) begin
      errors++;
      $display("FAIL abort_dump_outputs: en_read=%b others=%h, expected en_read=1 others=0", o_en_read, other_outs());
    end
    repeat (40) tick();
    checks++;
    if (tx_cnt !== tx0) begin
      errors++;
      $display("FAIL abort_dump_tx: got %0d tx strobes after reset, expected 0", tx_cnt - tx0);
    end
    model_cycles = 0;
    $display("test_abort: done");
  endtask

  initial begin
    test_reset();
    test_load();
    test_load_zero();
    test_random_load();
    test_ignore();
    test_run();
    test_step();
    test_step_halted();
    test_tx_stall();
    test_abort();
    test_step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
